// File: rtl/sound_pkg.sv
// Shared types and default tone durations for the sound event sequencer.
package sound_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    JUMP  = 3'd1,
    GAP   = 3'd2,
    DEATH = 3'd3,
    DONE  = 3'd4
  } snd_state_t;

  localparam int unsigned SND_JUMP_CYCLES  = 25_000_000;
  localparam int unsigned SND_DEATH_CYCLES = 100_000_000;
  localparam int unsigned SND_GAP_CYCLES   = 2_000_000;
  localparam int unsigned SND_TEST_JUMP    = 64;
  localparam int unsigned SND_TEST_DEATH   = 128;
  localparam int unsigned SND_TEST_GAP     = 8;

  localparam int SND_CNT_W = $clog2(SND_DEATH_CYCLES);

  function automatic int unsigned snd_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/duration_timer.sv
// Loadable down-counter; expired is high whenever the count has reached zero.
// A load takes effect on the next edge and wins over the decrement.
module duration_timer
  import sound_pkg::*;
#(
  parameter int W = SND_CNT_W
) (
  input  logic         CLK100MHZ,
  input  logic         CPU_RESETN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/sound_event_sequencer.sv
// Converts jump/death/revive pulses into level-held tone requests for audio_engine.
// Outputs are registered: an event sampled on edge N is visible right after edge N.
module sound_event_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned JUMP_CYCLES  = SND_JUMP_CYCLES,
  parameter int unsigned DEATH_CYCLES = SND_DEATH_CYCLES,
  parameter int unsigned GAP_CYCLES   = SND_GAP_CYCLES,
  parameter int unsigned TEST_JUMP    = SND_TEST_JUMP,
  parameter int unsigned TEST_DEATH   = SND_TEST_DEATH,
  parameter int unsigned TEST_GAP     = SND_TEST_GAP
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic jump_evt,
  input  logic death_evt,
  input  logic revive,
  input  logic istesting,
  output logic jump,
  output logic isdead,
  output logic busy
);

  localparam int unsigned MAX_DUR = snd_max(snd_max(snd_max(JUMP_CYCLES, DEATH_CYCLES),
                                                    snd_max(GAP_CYCLES, TEST_JUMP)),
                                            snd_max(TEST_DEATH, TEST_GAP));
  localparam int CNT_W = $clog2(MAX_DUR);

  snd_state_t       r_state;
  snd_state_t       w_next;
  logic             r_pend;
  logic             w_pend_nx;
  logic             r_jump;
  logic             r_isdead;
  logic             r_busy;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_expired;
  logic [CNT_W-1:0] w_jump_ld;
  logic [CNT_W-1:0] w_death_ld;
  logic [CNT_W-1:0] w_gap_ld;

  // Counter is loaded with length-1 so a state lasts exactly 'length' cycles.
  assign w_jump_ld  = istesting ? CNT_W'(TEST_JUMP - 1)  : CNT_W'(JUMP_CYCLES - 1);
  assign w_death_ld = istesting ? CNT_W'(TEST_DEATH - 1) : CNT_W'(DEATH_CYCLES - 1);
  assign w_gap_ld   = istesting ? CNT_W'(TEST_GAP - 1)   : CNT_W'(GAP_CYCLES - 1);

  duration_timer #(
    .W (CNT_W)
  ) u_timer (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .load       (w_load),
    .load_val   (w_load_val),
    .expired    (w_expired)
  );

  always_comb begin
    w_next     = r_state;
    w_pend_nx  = r_pend;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: begin
        if (death_evt) begin
          w_next     = DEATH;
          w_pend_nx  = 1'b0;
          w_load     = 1'b1;
          w_load_val = w_death_ld;
        end else if (jump_evt) begin
          w_next     = JUMP;
          w_load     = 1'b1;
          w_load_val = w_jump_ld;
        end
      end
      JUMP: begin
        if (death_evt) begin
          w_next     = DEATH;
          w_pend_nx  = 1'b0;
          w_load     = 1'b1;
          w_load_val = w_death_ld;
        end else begin
          if (jump_evt) w_pend_nx = 1'b1;
          // A retrigger landing on the expiry edge still earns a restart.
          if (w_expired) begin
            if (r_pend || jump_evt) begin
              w_next     = GAP;
              w_load     = 1'b1;
              w_load_val = w_gap_ld;
            end else begin
              w_next     = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (death_evt) begin
          w_next     = DEATH;
          w_pend_nx  = 1'b0;
          w_load     = 1'b1;
          w_load_val = w_death_ld;
        end else if (w_expired) begin
          w_next     = JUMP;
          w_pend_nx  = jump_evt;
          w_load     = 1'b1;
          w_load_val = w_jump_ld;
        end else if (jump_evt) begin
          w_pend_nx  = 1'b1;
        end
      end
      DEATH: begin
        if (revive) begin
          w_next    = IDLE;
          w_pend_nx = 1'b0;
        end else if (w_expired) begin
          w_next    = DONE;
        end
      end
      DONE: begin
        if (revive) begin
          w_next    = IDLE;
          w_pend_nx = 1'b0;
        end
      end
      default: begin
        w_next    = IDLE;
        w_pend_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state  <= IDLE;
      r_pend   <= 1'b0;
      r_jump   <= 1'b0;
      r_isdead <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_pend   <= w_pend_nx;
      r_jump   <= (w_next == JUMP);
      r_isdead <= (w_next == DEATH);
      r_busy   <= (w_next != IDLE);
    end
  end

  assign jump   = r_jump;
  assign isdead = r_isdead;
  assign busy   = r_busy;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Scoreboard bench: each scenario queues the expected output transitions (edge stamp + value),
// and a negedge monitor pops and compares them whenever {jump,isdead,busy} changes.
module tb_sound_event_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic jump_evt, death_evt, revive, istesting;
  logic jump, isdead, busy;

  always #5 clk = ~clk;

  sound_event_sequencer dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .jump_evt   (jump_evt),
    .death_evt  (death_evt),
    .revive     (revive),
    .istesting  (istesting),
    .jump       (jump),
    .isdead     (isdead),
    .busy       (busy)
  );

  typedef struct {
    int         stamp;
    logic [2:0] val;
  } exp_t;

  exp_t       q[$];
  int         edge_n   = 0;
  int         checks   = 0;
  int         failures = 0;
  bit         mon_en   = 1'b0;
  logic [2:0] prev     = 3'b000;
  logic [2:0] cur;
  exp_t       e;
  int         t0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // {jump,isdead,busy}
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {jump, isdead, busy};
      checks++;
      if (jump && isdead) begin
        failures++;
        $display("FAIL overlap: jump and isdead both high at edge %0d", edge_n);
      end
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change: outputs=%b at edge %0d, none expected", cur, edge_n);
        end else begin
          e = q.pop_front();
          if (e.val !== cur || e.stamp != edge_n) begin
            failures++;
            $display("FAIL transition: got %b at edge %0d, expected %b at edge %0d",
                     cur, edge_n, e.val, e.stamp);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic push(input int stamp, input logic [2:0] val);
    exp_t x;
    x.stamp = stamp;
    x.val   = val;
    q.push_back(x);
  endtask

  // Drive a one-cycle pulse so it is sampled on edge e; returns at a negedge.
  task automatic pulse(input int e_at, input logic j, input logic d, input logic r);
    while (edge_n < e_at - 1) @(negedge clk);
    if (edge_n != e_at - 1) begin
      failures++;
      $display("FAIL schedule: pulse for edge %0d issued at edge %0d", e_at, edge_n);
    end
    jump_evt  = j;
    death_evt = d;
    revive    = r;
    @(negedge clk);
    jump_evt  = 1'b0;
    death_evt = 1'b0;
    revive    = 1'b0;
  endtask

  task automatic wait_to(input int e_at);
    while (edge_n < e_at) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    jump_evt  = 1'b0;
    death_evt = 1'b0;
    revive    = 1'b0;
    istesting = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_jump", {31'd0, jump}, 32'd0);
    chk("reset_isdead", {31'd0, isdead}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // 1: single jump, 64 cycles
    t0 = edge_n;
    push(t0 + 10, 3'b101);
    push(t0 + 74, 3'b000);
    pulse(t0 + 10, 1'b1, 1'b0, 1'b0);
    wait_to(t0 + 90);

    // 2: retrigger -> jump, 8-cycle gap, jump
    t0 = edge_n;
    push(t0 + 10,  3'b101);
    push(t0 + 74,  3'b001);
    push(t0 + 82,  3'b101);
    push(t0 + 146, 3'b000);
    pulse(t0 + 10, 1'b1, 1'b0, 1'b0);
    pulse(t0 + 30, 1'b1, 1'b0, 1'b0);
    pulse(t0 + 31, 1'b1, 1'b0, 1'b0);
    wait_to(t0 + 160);

    // 3: death aborts jump, DONE ignores jump, revive returns to idle
    t0 = edge_n;
    push(t0 + 10,  3'b101);
    push(t0 + 20,  3'b011);
    push(t0 + 148, 3'b001);
    push(t0 + 210, 3'b000);
    pulse(t0 + 10,  1'b1, 1'b0, 1'b0);
    pulse(t0 + 20,  1'b0, 1'b1, 1'b0);
    pulse(t0 + 60,  1'b0, 1'b1, 1'b0);
    pulse(t0 + 200, 1'b1, 1'b0, 1'b0);
    pulse(t0 + 205, 1'b0, 1'b1, 1'b0);
    pulse(t0 + 210, 1'b0, 1'b0, 1'b1);
    wait_to(t0 + 220);

    // 4: simultaneous jump+death -> death only; revive+jump in DONE -> idle
    t0 = edge_n;
    push(t0 + 10,  3'b011);
    push(t0 + 138, 3'b001);
    push(t0 + 150, 3'b000);
    pulse(t0 + 5,   1'b0, 1'b0, 1'b1);
    pulse(t0 + 10,  1'b1, 1'b1, 1'b0);
    pulse(t0 + 150, 1'b1, 1'b0, 1'b1);
    wait_to(t0 + 160);
    chk("s4_idle_after_revive_jump", {29'd0, jump, isdead, busy}, 32'd0);

    // 5: async reset mid-death, then a normal jump
    t0 = edge_n;
    push(t0 + 10, 3'b011);
    push(t0 + 50, 3'b000);
    pulse(t0 + 10, 1'b0, 1'b1, 1'b0);
    wait_to(t0 + 49);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_isdead", {31'd0, isdead}, 32'd0);
    chk("s5_async_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t0 = edge_n;
    push(t0 + 5,  3'b101);
    push(t0 + 69, 3'b000);
    pulse(t0 + 5, 1'b1, 1'b0, 1'b0);
    wait_to(t0 + 80);

    // 6: full-length durations; jump must still be high long after the test length
    istesting = 1'b0;
    @(negedge clk);
    t0 = edge_n;
    push(t0 + 5, 3'b101);
    pulse(t0 + 5, 1'b1, 1'b0, 1'b0);
    wait_to(t0 + 2005);
    chk("s6_jump_still_high", {31'd0, jump}, 32'd1);
    chk("s6_queue_drained", q.size(), 32'd0);
    push(edge_n + 1, 3'b000);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    istesting = 1'b1;
    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_event_sequencer.md
# sound_event_sequencer

Turns single-cycle game event pulses into the level-held `jump` and `isdead` request signals consumed by `audio_engine`. It sits directly upstream of `audio_engine`, between game logic and the tone generator. It decides:
- how long each tone plays;
- which tone wins on conflicting events;
- how a re-triggered jump gets a clean restart. The engine resets its pitch only while both requests are low, so a restart needs an idle gap.

## Interface
Parameters:
- `JUMP_CYCLES`, 25_000_000: jump tone length in clocks (250 ms).
- `DEATH_CYCLES`, 100_000_000: death tone length in clocks (1 s).
- `GAP_CYCLES`, 2_000_000: forced silence before a re-triggered jump (20 ms).
- `TEST_JUMP`, 64; `TEST_DEATH`, 128; `TEST_GAP`, 8: durations used when `istesting`=1.

Ports:
- `CLK100MHZ`  in  1: single system clock; all logic is on its rising edge.
- `CPU_RESETN`  in  1: asynchronous, active-low reset.
- `jump_evt`  in  1: one-cycle pulse when the player jumps.
- `death_evt`  in  1: one-cycle pulse when the player dies.
- `revive`  in  1: one-cycle pulse when a new game starts.
- `istesting`  in  1: selects the TEST_* durations; assumed static during operation.
- `jump`  out  1: registered jump-tone request to `audio_engine`.
- `isdead`  out  1: registered death-tone request to `audio_engine`.
- `busy`  out  1: registered; 1 in every state except IDLE.

## Operation
- States: IDLE, JUMP, GAP, DEATH, DONE.
- One down-counter `cnt`. Width = clog2 of the largest duration. It is loaded with duration−1 on state entry, and the state expires when `cnt`==0.
- Durations come from the parameters. When `istesting`=1, each duration is replaced by the matching TEST_* value.
- `pend` is a one-bit retrigger flag.
- Per-state outputs:
  - JUMP: `jump`=1, `isdead`=0.
  - DEATH: `isdead`=1, `jump`=0.
  - IDLE, GAP, DONE: both 0.
- Transitions, evaluated in priority order each cycle:
  1. `revive` in DEATH or DONE → IDLE; `pend` cleared. `revive` is ignored in every other state.
  2. `death_evt` in IDLE, JUMP or GAP → DEATH; `pend` cleared. `death_evt` is ignored in DEATH and DONE, so the tone is not restarted.
  3. `jump_evt` in IDLE → JUMP.
  4. `jump_evt` in JUMP or GAP sets `pend`. Duplicate pulses do not stack.
  5. `jump_evt` in DEATH or DONE is discarded.
  6. JUMP expiry → GAP if `pend`, else IDLE.
  7. GAP expiry → JUMP, clearing `pend`. A `jump_evt` on that same edge re-sets `pend`.
  8. DEATH expiry → DONE. DONE holds until `revive`.
- Simultaneous events on one edge:
  - `jump_evt`+`death_evt` in IDLE, JUMP or GAP → DEATH only.
  - `revive`+`death_evt` in DONE → IDLE. The death pulse is dropped.
  - `revive`+`jump_evt` in DEATH or DONE → IDLE. The jump pulse is dropped.
- Reset (asserted at any time, including mid-tone): state=IDLE, `cnt`=0, `pend`=0, `jump`=`isdead`=`busy`=0, all immediately (asynchronous). Release is synchronous to `CLK100MHZ`.

## Timing
- Outputs are registered. An event sampled at edge N changes the outputs after edge N; latency is 1 cycle.
- `jump` stays high for exactly JUMP_CYCLES (or TEST_JUMP) consecutive cycles per activation.
- `isdead` stays high for exactly DEATH_CYCLES (or TEST_DEATH) consecutive cycles.
- GAP keeps both outputs low for exactly GAP_CYCLES (or TEST_GAP) cycles. There is never a cycle with both `jump` and `isdead` high.
- Abort from JUMP or GAP into DEATH: `jump` falls and `isdead` rises on the same edge.
- Inputs are synchronous to `CLK100MHZ`. A pulse longer than one cycle counts as repeated events.

## Structure
- Package `sound_pkg`:
  - state enum `snd_state_t` with IDLE, JUMP, GAP, DEATH, DONE;
  - `SND_CNT_W` localparam;
  - the default duration constants.
- Sub-module `duration_timer`: loadable down-counter with inputs `load`, `load_val` and output `expired`. It takes the same clock and reset.
- The FSM and priority logic live in the top. The top is instantiated next to `audio_engine`, with `jump`/`isdead` wired straight to it.

## Test plan
All scenarios use `istesting`=1.
1. `jump_evt` at cycle 10 → `jump` high over cycles 11–74 (64 cycles), then low; `busy` falls with it.
2. `jump_evt` at 10 and again at 30 → `jump` high 11–74, low 75–82 (8-cycle gap), high 83–146.
3. `jump_evt` at 10, `death_evt` at 20 → `jump` falls and `isdead` rises after edge 20. `isdead` is high 21–148, then DONE with `busy`=1. A `jump_evt` at 200 → no output. `revive` at 210 → `busy`=0 after edge 210.
4. `jump_evt` and `death_evt` together at 10 → only `isdead` high, for 128 cycles; `jump` stays 0 throughout.
5. `death_evt` at 10, `CPU_RESETN` low at cycle 50 (asynchronously) → `isdead`=`busy`=0 immediately. After release, a `jump_evt` yields a normal 64-cycle `jump`.
6. `istesting`=0 with defaults, `jump_evt` → `jump` high for exactly 25_000_000 cycles (counter-width check).
